// File: rtl/shake256_pkg.sv
// Shared constants and FSM state type for the SHAKE256 sponge controller.
// The optional length check is enabled with the SHAKE_LEN_CHECK_EN macro.
package shake256_pkg;

    localparam int RATE       = 1088;
    localparam int LEN_W      = 11;
    localparam int CNT_W      = 8;
    localparam int PAD_THRESH = 1083;

    typedef enum logic [2:0] {
        IDLE,
        ABS_ISSUE,
        ABS_WAIT,
        EXTRA_ISSUE,
        EXTRA_WAIT,
        SQ_OUT,
        SQ_ISSUE,
        SQ_WAIT
    } sponge_state_t;

endpackage

// File: rtl/shake256_sq_counter.sv
// Squeeze-block down-counter: loads the requested count (0 means 1),
// decrements per delivered block and flags when the decrement reaches zero.
module shake256_sq_counter
    import shake256_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             dec_zero
);

    logic [CNT_W-1:0] sq_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_cnt <= '0;
        end else if (load) begin
            sq_cnt <= (load_val == '0) ? CNT_W'(1) : load_val;
        end else if (dec) begin
            sq_cnt <= sq_cnt - CNT_W'(1);
        end
    end

    assign dec_zero = (sq_cnt <= CNT_W'(1));

endmodule

// File: rtl/shake256_sponge_ctrl.sv
// SHAKE256 absorb/squeeze sequencer driving an external Keccak-f[1600] core.
// Define SHAKE_LEN_CHECK_EN to add the sticky err output and block-length check.
module shake256_sponge_ctrl
    import shake256_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [RATE-1:0]  blk_data,
    input  logic [LEN_W-1:0] blk_len,
    input  logic             blk_last,
    input  logic [CNT_W-1:0] sq_blocks,
    output logic [RATE-1:0]  pad_in,
    output logic [LEN_W-1:0] pad_len,
    input  logic [RATE-1:0]  pad_out,
    input  logic [RATE-1:0]  pad_next,
    output logic             perm_start,
    output logic [RATE-1:0]  perm_block,
    output logic             perm_clear,
    input  logic             perm_done,
    input  logic [RATE-1:0]  sq_rate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RATE-1:0]  out_data,
    output logic             busy
`ifdef SHAKE_LEN_CHECK_EN
    ,
    output logic             err
`endif
);

    sponge_state_t   state, state_nxt;
    logic [RATE-1:0] extra_q;
    logic            last_q, need_extra_q, in_msg_q;
    logic            len_bad, accept, sq_dec, dec_zero;

    assign pad_in  = blk_data;
    assign pad_len = blk_last ? blk_len : LEN_W'(RATE);

    assign blk_ready = (state == IDLE) || (state == ABS_WAIT && perm_done && !last_q);

`ifdef SHAKE_LEN_CHECK_EN
    assign len_bad = (blk_len > LEN_W'(RATE)) || (!blk_last && blk_len != LEN_W'(RATE));
`else
    assign len_bad = 1'b0;
`endif
    assign accept = blk_valid && blk_ready && !len_bad;

    assign busy     = (state != IDLE);
    assign out_data = sq_rate;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_nxt  = state;
        perm_start = 1'b0;
        perm_clear = 1'b0;
        out_valid  = 1'b0;
        sq_dec     = 1'b0;
        case (state)
            IDLE:        if (accept) state_nxt = ABS_ISSUE;
            ABS_ISSUE: begin
                perm_start = 1'b1;
                state_nxt  = ABS_WAIT;
            end
            ABS_WAIT: if (perm_done) begin
                if (!last_q)           state_nxt = accept ? ABS_ISSUE : IDLE;
                else if (need_extra_q) state_nxt = EXTRA_ISSUE;
                else                   state_nxt = SQ_OUT;
            end
            EXTRA_ISSUE: begin
                perm_start = 1'b1;
                state_nxt  = EXTRA_WAIT;
            end
            EXTRA_WAIT:  if (perm_done) state_nxt = SQ_OUT;
            SQ_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    sq_dec = 1'b1;
                    if (dec_zero) begin
                        perm_clear = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        state_nxt = SQ_ISSUE;
                    end
                end
            end
            SQ_ISSUE: begin
                perm_start = 1'b1;
                state_nxt  = SQ_WAIT;
            end
            SQ_WAIT:     if (perm_done) state_nxt = SQ_OUT;
            default:     state_nxt = IDLE;
        endcase
    end

    // perm_block is loaded on entry to each ISSUE state so it is stable while perm_start is high.
    // NOTE: the wide block registers are reset too, so a mid-operation reset
    // never leaves stale message bits visible on perm_block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            perm_block   <= '0;
            extra_q      <= '0;
            last_q       <= 1'b0;
            need_extra_q <= 1'b0;
            in_msg_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                perm_block <= pad_out;
                last_q     <= blk_last;
                in_msg_q   <= !blk_last;
                if (blk_last) begin
                    extra_q      <= pad_next;
                    need_extra_q <= (blk_len >= LEN_W'(PAD_THRESH));
                end
            end else if (state_nxt == EXTRA_ISSUE) begin
                perm_block <= extra_q;
            end else if (state_nxt == SQ_ISSUE) begin
                perm_block <= '0;
            end
        end
    end

`ifdef SHAKE_LEN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              err <= 1'b0;
        else if (blk_valid && blk_ready && len_bad) err <= 1'b1;
    end
`endif

    shake256_sq_counter u_sq_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && !in_msg_q),
        .load_val (sq_blocks),
        .dec      (sq_dec),
        .dec_zero (dec_zero)
    );

endmodule

// File: tb/tb_shake256_sponge_ctrl.sv
// Directed bench for shake256_sponge_ctrl with behavioural pad unit and Keccak core models.
module tb_shake256_sponge_ctrl;
    import shake256_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             blk_valid, blk_ready, blk_last;
    logic [RATE-1:0]  blk_data;
    logic [LEN_W-1:0] blk_len;
    logic [CNT_W-1:0] sq_blocks;
    logic [RATE-1:0]  pad_in, pad_out, pad_next;
    logic [LEN_W-1:0] pad_len;
    logic             perm_start, perm_clear, perm_done;
    logic [RATE-1:0]  perm_block, sq_rate, out_data;
    logic             out_valid, out_ready, busy;
`ifdef SHAKE_LEN_CHECK_EN
    logic             err;
`endif

    int checks = 0, errors = 0;
    int starts = 0, clears = 0, out_hs = 0, perm_cnt = 0, pending = 0;
    logic [RATE-1:0] blocks [64];
    logic [RATE-1:0] outs   [64];

    always #5 clk = ~clk;

    shake256_sponge_ctrl dut (
        .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .blk_len(blk_len), .blk_last(blk_last), .sq_blocks(sq_blocks),
        .pad_in(pad_in), .pad_len(pad_len), .pad_out(pad_out), .pad_next(pad_next),
        .perm_start(perm_start), .perm_block(perm_block), .perm_clear(perm_clear),
        .perm_done(perm_done), .sq_rate(sq_rate), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef SHAKE_LEN_CHECK_EN
        , .err(err)
`endif
    );

    // SHAKE padding: 1111 suffix at bit len, final 1 at the top of the (possibly next) block.
    function automatic logic [2*RATE-1:0] pad_ref(input logic [RATE-1:0] d, input int len);
        logic [2*RATE-1:0] v;
        v = '0;
        for (int i = 0; i < len && i < RATE; i++) v[i] = d[i];
        for (int i = 0; i < 5; i++) v[len+i] = 1'b1;
        if (len <= 1082) v[RATE-1] = 1'b1;
        else             v[2*RATE-1] = 1'b1;
        return v;
    endfunction

    function automatic logic [RATE-1:0] pat(input int n);
        return {34{n[31:0]}};
    endfunction

    logic [2*RATE-1:0] pad_v;
    always_comb begin
        pad_v    = pad_ref(pad_in, int'(pad_len));
        pad_out  = pad_v[RATE-1:0];
        pad_next = pad_v[2*RATE-1:RATE];
    end

    // Core model: perm_done three cycles after perm_start; state rate becomes pat(perm count).
    initial begin
        perm_done = 1'b0;
        sq_rate   = '0;
        forever begin
            @(posedge clk); #1;
            perm_done = 1'b0;
            if (!rst_n) begin
                pending = 0;
            end else if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    perm_done = 1'b1;
                    perm_cnt++;
                    sq_rate = pat(perm_cnt);
                end
            end
            @(negedge clk);
            if (rst_n && perm_start) begin
                blocks[starts % 64] = perm_block;
                starts++;
                pending = 3;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && perm_clear) clears++;
            if (rst_n && out_valid && out_ready) begin
                outs[out_hs % 64] = out_data;
                out_hs++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [RATE-1:0] obs, input logic [RATE-1:0] exp);
        int w;
        checks++;
        assert (obs === exp) else begin
            errors++;
            w = 0;
            for (int i = 0; i < RATE/32; i++) if (obs[i*32 +: 32] !== exp[i*32 +: 32]) begin w = i; break; end
            $error("FAIL %s word %0d observed=%h expected=%h", tag, w, obs[w*32 +: 32], exp[w*32 +: 32]);
        end
    endtask

    task automatic send_block(input logic [RATE-1:0] d, input int len, input logic last, input int sq);
        bit ok = 0;
        blk_valid = 1'b1; blk_data = d; blk_len = LEN_W'(len); blk_last = last; sq_blocks = CNT_W'(sq);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (blk_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        blk_valid = 1'b0;
        check("handshake_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        check("idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_out_valid();
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        check("out_valid_timeout", 64'(ok), 64'd1);
    endtask

    logic [RATE-1:0] d, e, held;
    int s0, c0, o0, p0;

    initial begin
        blk_valid = 1'b0; blk_data = '0; blk_len = '0; blk_last = 1'b0; sq_blocks = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_blk_ready", 64'(blk_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_perm_start", 64'(perm_start), 64'd0);
        check("rst_perm_clear", 64'(perm_clear), 64'd0);
        check_wide("rst_perm_block", perm_block, '0);
`ifdef SHAKE_LEN_CHECK_EN
        check("rst_err", 64'(err), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Empty message, one squeeze block.
        d = {34{32'hDEADBEEF}};
        s0 = starts; c0 = clears; o0 = out_hs;
        send_block(d, 0, 1'b1, 1);
        wait_idle();
        e = '0; e[4:0] = 5'h1F; e[RATE-1] = 1'b1;
        check("len0_starts", 64'(starts - s0), 64'd1);
        check("len0_byte0", 64'(blocks[s0 % 64][7:0]), 64'h1F);
        check_wide("len0_block", blocks[s0 % 64], e);
        check("len0_outs", 64'(out_hs - o0), 64'd1);
        check("len0_clears", 64'(clears - c0), 64'd1);

        // Full last block needs the padding-only extra block.
        d = {34{32'h0123_4567}};
        s0 = starts; o0 = out_hs;
        send_block(d, 1088, 1'b1, 0);
        wait_idle();
        check("len1088_starts", 64'(starts - s0), 64'd2);
        check_wide("len1088_first", blocks[s0 % 64], d);
        check_wide("len1088_extra", blocks[(s0 + 1) % 64], e);
        check("len1088_outs", 64'(out_hs - o0), 64'd1);

        // Boundary: 1082 fits, 1083 spills into an extra block.
        d = {34{32'hF0F0_3C3C}};
        s0 = starts;
        send_block(d, 1082, 1'b1, 1);
        wait_idle();
        check("len1082_starts", 64'(starts - s0), 64'd1);
        check("len1082_tail", 64'(blocks[s0 % 64][RATE-1:1082]), 64'h3F);
        e = d; e[RATE-1:1082] = 6'h3F;
        check_wide("len1082_block", blocks[s0 % 64], e);
        s0 = starts;
        send_block(d, 1083, 1'b1, 1);
        wait_idle();
        check("len1083_starts", 64'(starts - s0), 64'd2);
        e = '0; e[RATE-1] = 1'b1;
        check_wide("len1083_extra", blocks[(s0 + 1) % 64], e);

        // Two full blocks, then a short last block, three squeeze blocks.
        s0 = starts; o0 = out_hs; p0 = perm_cnt; c0 = clears;
        send_block({34{32'h1111_1111}}, 1088, 1'b0, 3);
        send_block({34{32'h2222_2222}}, 1088, 1'b0, 7);
        send_block({34{32'h0000_00AB}}, 8, 1'b1, 0);
        wait_idle();
        e = '0; e[7:0] = 8'hAB; e[12:8] = 5'h1F; e[RATE-1] = 1'b1;
        check("multi_starts", 64'(starts - s0), 64'd5);
        check_wide("multi_blk0", blocks[s0 % 64], {34{32'h1111_1111}});
        check_wide("multi_blk1", blocks[(s0 + 1) % 64], {34{32'h2222_2222}});
        check_wide("multi_blk2", blocks[(s0 + 2) % 64], e);
        check_wide("multi_sq0", blocks[(s0 + 3) % 64], '0);
        check_wide("multi_sq1", blocks[(s0 + 4) % 64], '0);
        check("multi_outs", 64'(out_hs - o0), 64'd3);
        check_wide("multi_out0", outs[o0 % 64], pat(p0 + 3));
        check_wide("multi_out1", outs[(o0 + 1) % 64], pat(p0 + 4));
        check_wide("multi_out2", outs[(o0 + 2) % 64], pat(p0 + 5));
        check("multi_clears", 64'(clears - c0), 64'd1);

        // Back-pressure in SQ_OUT.
        out_ready = 1'b0;
        c0 = clears;
        send_block({34{32'h5555_AAAA}}, 16, 1'b1, 1);
        wait_out_valid();
        held = out_data;
        s0 = starts;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check_wide("stall_data", out_data, held);
        end
        @(posedge clk); #1;
        check("stall_starts", 64'(starts - s0), 64'd0);
        out_ready = 1'b1;
        wait_idle();
        check("stall_clears", 64'(clears - c0), 64'd1);

`ifdef SHAKE_LEN_CHECK_EN
        s0 = starts;
        send_block({34{32'h7777_7777}}, 512, 1'b0, 1);
        repeat (5) @(negedge clk);
        check("lenchk_err", 64'(err), 64'd1);
        check("lenchk_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("lenchk_starts", 64'(starts - s0), 64'd0);
`endif

        // Reset asserted while waiting on a squeeze permutation.
        c0 = clears;
        send_block({34{32'h9999_0000}}, 0, 1'b1, 2);
        wait_out_valid();
        @(negedge clk);
        @(negedge clk);
        check("sqwait_busy", 64'(busy), 64'd1);
        check("sqwait_perm_start", 64'(perm_start), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_blk_ready", 64'(blk_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_perm_clear", 64'(perm_clear), 64'd0);
        check_wide("midrst_perm_block", perm_block, '0);
`ifdef SHAKE_LEN_CHECK_EN
        check("midrst_err", 64'(err), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_clears", 64'(clears - c0), 64'd0);

        o0 = out_hs;
        send_block({34{32'h0F0F_0F0F}}, 32, 1'b1, 1);
        wait_idle();
        check("postrst_outs", 64'(out_hs - o0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
